// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store memory master.
package lsu_pkg;

    localparam int LINE_BYTES = 8;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } lsu_size_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } lsu_state_e;

    // Byte-lane mask of an access of the given size starting at lane off.
    // Lanes past the end of the line fall off the top of the 8-bit result.
    function automatic logic [LINE_BYTES-1:0] size_mask(input lsu_size_e size,
                                                        input logic [2:0] off);
        logic [LINE_BYTES-1:0] w_base;
        case (size)
            SZ_B:    w_base = 8'h01;
            SZ_H:    w_base = 8'h03;
            SZ_W:    w_base = 8'h0F;
            default: w_base = 8'hFF;
        endcase
        return w_base << off;
    endfunction

    // Low address bits that must be zero for a naturally aligned access.
    function automatic logic [2:0] align_bits(input lsu_size_e size);
        case (size)
            SZ_B:    return 3'b000;
            SZ_H:    return 3'b001;
            SZ_W:    return 3'b011;
            default: return 3'b111;
        endcase
    endfunction

endpackage

// File: rtl/lsu_mem_master_if.sv
// Request/response handshake plus the data-memory port of the LSU.
interface lsu_mem_master_if;
    import lsu_pkg::*;

    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;

    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_err;

    logic        men;
    logic        mwen;
    logic [63:0] raddr;
    logic [63:0] rdata;
    logic [63:0] waddr;
    logic [63:0] wdata;
    logic [LINE_BYTES-1:0] wmask;

    // The LSU side: takes requests and drives the memory port.
    modport master (
        input  req_valid, req_wen, req_size, req_unsigned, req_addr, req_wdata,
        input  resp_ready, rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output men, mwen, raddr, waddr, wdata, wmask
    );

    // The pipeline + memory model side.
    modport slave (
        output req_valid, req_wen, req_size, req_unsigned, req_addr, req_wdata,
        output resp_ready, rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  men, mwen, raddr, waddr, wdata, wmask
    );

endinterface

// File: rtl/lsu_load_align.sv
// Extracts the addressed bytes from a memory line and sign/zero-extends them.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [63:0] i_rdata,
    input  logic [2:0]  i_off,
    input  lsu_size_e   i_size,
    input  logic        i_unsigned,
    output logic [63:0] o_result
);

    logic [63:0] w_shifted;

    // Shift the addressed byte down to lane 0, then keep and extend per size.
    always_comb begin
        w_shifted = i_rdata >> {i_off, 3'b000};
        // NOTE: o_result gets a value before the case so no path leaves it unassigned (no latch).
        o_result  = w_shifted;
        case (i_size)
            SZ_B:    o_result = {{56{~i_unsigned & w_shifted[7]}},  w_shifted[7:0]};
            SZ_H:    o_result = {{48{~i_unsigned & w_shifted[15]}}, w_shifted[15:0]};
            SZ_W:    o_result = {{32{~i_unsigned & w_shifted[31]}}, w_shifted[31:0]};
            default: o_result = w_shifted;
        endcase
    end

endmodule

// File: rtl/lsu_mem_master.sv
// Single-outstanding load/store master: one aligned 8-byte beat per request,
// result returned through a valid/ready response held until accepted.
module lsu_mem_master
    import lsu_pkg::*;
#(
    parameter bit CHECK_ALIGN = 1'b1
) (
    input logic             clk,
    input logic             rst,
    lsu_mem_master_if.master bus
);

    localparam logic [1:0] S_IDLE   = IDLE;
    localparam logic [1:0] S_ACCESS = ACCESS;
    localparam logic [1:0] S_RESP   = RESP;

    logic [1:0]  r_state;
    logic        r_wen;
    lsu_size_e   r_size;
    logic        r_unsigned;
    logic [2:0]  r_off;
    logic [60:0] r_line;
    logic [63:0] r_wdata;
    logic [7:0]  r_wmask;
    logic        r_men;
    logic        r_mwen;
    logic        r_resp_valid;
    logic [63:0] r_resp_rdata;
    logic        r_err;

    lsu_size_e   w_size;
    logic        w_misaligned;
    logic [63:0] w_load_result;

    assign w_size       = lsu_size_e'(bus.req_size);
    assign w_misaligned = CHECK_ALIGN && ((bus.req_addr[2:0] & align_bits(w_size)) != 3'b000);

    lsu_load_align u_load_align (
        .i_rdata    (bus.rdata),
        .i_off      (r_off),
        .i_size     (r_size),
        .i_unsigned (r_unsigned),
        .o_result   (w_load_result)
    );

    // Memory-side outputs come straight from registers so men/mwen never glitch.
    assign bus.req_ready  = (r_state == S_IDLE);
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_rdata = r_resp_rdata;
    assign bus.resp_err   = r_err;
    assign bus.men        = r_men;
    assign bus.mwen       = r_mwen;
    assign bus.raddr      = {r_line, 3'b000};
    assign bus.waddr      = {r_line, 3'b000};
    assign bus.wdata      = r_wdata;
    assign bus.wmask      = r_wmask;

    // IDLE -> ACCESS -> RESP (or IDLE -> RESP on misalignment) with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_wen        <= 1'b0;
            r_size       <= SZ_B;
            r_unsigned   <= 1'b0;
            r_off        <= 3'd0;
            r_line       <= '0;
            r_wdata      <= '0;
            r_wmask      <= '0;
            r_men        <= 1'b0;
            r_mwen       <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_err        <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every update here see pre-edge values.
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_wen        <= bus.req_wen;
                        r_size       <= w_size;
                        r_unsigned   <= bus.req_unsigned;
                        r_off        <= bus.req_addr[2:0];
                        r_line       <= bus.req_addr[63:3];
                        r_wdata      <= bus.req_wdata << {bus.req_addr[2:0], 3'b000};
                        r_resp_rdata <= '0;
                        if (w_misaligned) begin
                            // Fault without touching memory; respond next cycle.
                            r_err        <= 1'b1;
                            r_resp_valid <= 1'b1;
                            r_state      <= S_RESP;
                        end else begin
                            r_err   <= 1'b0;
                            r_men   <= 1'b1;
                            r_mwen  <= bus.req_wen;
                            r_wmask <= size_mask(w_size, bus.req_addr[2:0]);
                            r_state <= S_ACCESS;
                        end
                    end
                end
                S_ACCESS: begin
                    // rdata is valid during this cycle; capture it as the cycle ends.
                    r_men        <= 1'b0;
                    r_mwen       <= 1'b0;
                    r_wmask      <= '0;
                    r_resp_valid <= 1'b1;
                    r_resp_rdata <= r_wen ? 64'd0 : w_load_result;
                    r_state      <= S_RESP;
                end
                S_RESP: begin
                    if (bus.resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_err        <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Self-checking bench for lsu_mem_master: directed vector table, reset and
// backpressure sequences, then random traffic against a byte-addressed model.
module tb_lsu_mem_master;

    typedef struct {
        logic        wen;
        logic [1:0]  size;
        logic        uns;
        logic [63:0] addr;
        logic [63:0] wdata;
    } req_t;

    typedef struct {
        logic        err;
        logic [63:0] rdata;
        logic [7:0]  wmask;
        logic [63:0] wdata;
    } exp_t;

    typedef struct {
        req_t        rq;
        logic        preload;
        logic [63:0] line;
        exp_t        ex;
        int          hold;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lsu_mem_master_if bus ();

    lsu_mem_master #(.CHECK_ALIGN(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int    n_checks = 0;
    int    n_fail   = 0;
    string cur_tag  = "init";

    // Memory seen by the DUT (written only through its write port) and the
    // reference memory updated by the model from the requests themselves.
    logic [7:0] dut_mem [logic [63:0]];
    logic [7:0] ref_mem [logic [63:0]];

    logic        pend_w = 1'b0;
    logic [63:0] pend_addr, pend_data;
    logic [7:0]  pend_mask;
    bit          in_txn = 1'b0;
    int          men_cnt;
    logic        cap_mwen;
    logic [63:0] cap_raddr, cap_waddr, cap_wdata;
    logic [7:0]  cap_wmask;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s/%s: got 0x%016h expected 0x%016h", cur_tag, name, act, exp);
        end
    endtask

    function automatic logic [7:0] init_byte(input logic [63:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    function automatic logic [7:0] dut_rd(input logic [63:0] a);
        return dut_mem.exists(a) ? dut_mem[a] : init_byte(a);
    endfunction

    function automatic logic [7:0] ref_rd(input logic [63:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
    endfunction

    task automatic preload(input logic [63:0] line_addr, input logic [63:0] line);
        for (int j = 0; j < 8; j++) begin
            dut_mem[line_addr + 64'(j)] = line[8*j +: 8];
            ref_mem[line_addr + 64'(j)] = line[8*j +: 8];
        end
    endtask

    // Reference model: byte-addressed memory, natural alignment rule.
    task automatic model(input req_t rq, output exp_t ex);
        int n;
        int off;
        logic [63:0] v;
        n        = 1 << rq.size;
        off      = int'(rq.addr[2:0]);
        ex.err   = (rq.addr % 64'(n)) != 64'd0;
        ex.rdata = '0;
        ex.wmask = '0;
        ex.wdata = '0;
        if (!ex.err) begin
            if (rq.wen) begin
                for (int i = 0; i < n; i++) begin
                    if (off + i < 8) ex.wmask[off + i] = 1'b1;
                    ref_mem[rq.addr + 64'(i)] = rq.wdata[8*i +: 8];
                end
                ex.wdata = rq.wdata << (8 * off);
            end else begin
                v = '0;
                for (int i = 0; i < n; i++) v[8*i +: 8] = ref_rd(rq.addr + 64'(i));
                if (!rq.uns && n < 8 && v[8*n-1]) v = v | ~((64'd1 << (8 * n)) - 64'd1);
                ex.rdata = v;
            end
        end
    endtask

    // Sample the memory port just after a negedge and act as the memory.
    task automatic sample();
        logic [63:0] line;
        if (bus.men) begin
            men_cnt++;
            cap_mwen  = bus.mwen;
            cap_raddr = bus.raddr;
            cap_waddr = bus.waddr;
            cap_wdata = bus.wdata;
            cap_wmask = bus.wmask;
            for (int j = 0; j < 8; j++) line[8*j +: 8] = dut_rd(bus.raddr + 64'(j));
            bus.rdata = line;
            if (bus.mwen) begin
                pend_w    = 1'b1;
                pend_addr = {bus.waddr[63:3], 3'b000};
                pend_mask = bus.wmask;
                pend_data = bus.wdata;
            end
            if (!in_txn) check("stray_men", 64'(bus.men), 64'd0);
        end else begin
            bus.rdata = {$urandom, $urandom};
            check("mwen_without_men", 64'(bus.mwen), 64'd0);
            check("wmask_without_men", 64'(bus.wmask), 64'd0);
        end
    endtask

    // One clock: commit a pending write at the edge (unless in reset), then sample.
    task automatic step();
        @(posedge clk);
        if (pend_w && !rst) begin
            for (int j = 0; j < 8; j++)
                if (pend_mask[j]) dut_mem[pend_addr + 64'(j)] = pend_data[8*j +: 8];
        end
        pend_w = 1'b0;
        @(negedge clk);
        sample();
    endtask

    task automatic run_txn(input req_t rq, input exp_t ex, input int hold);
        int          lat;
        logic [63:0] held_rdata;
        logic        held_err;
        logic [63:0] line_a;
        line_a  = {rq.addr[63:3], 3'b000};
        check("req_ready_idle", 64'(bus.req_ready), 64'd1);
        men_cnt = 0;
        in_txn  = 1'b1;
        bus.req_valid    = 1'b1;
        bus.req_wen      = rq.wen;
        bus.req_size     = rq.size;
        bus.req_unsigned = rq.uns;
        bus.req_addr     = rq.addr;
        bus.req_wdata    = rq.wdata;
        step();
        bus.req_valid = 1'b0;
        lat = 1;
        while (!bus.resp_valid && lat < 8) begin
            check("req_ready_busy", 64'(bus.req_ready), 64'd0);
            step();
            lat++;
        end
        check("resp_latency", 64'(lat), ex.err ? 64'd1 : 64'd2);
        check("resp_err", 64'(bus.resp_err), 64'(ex.err));
        check("resp_rdata", bus.resp_rdata, ex.rdata);
        held_rdata = bus.resp_rdata;
        held_err   = bus.resp_err;
        for (int k = 0; k < hold; k++) begin
            step();
            check("hold_valid", 64'(bus.resp_valid), 64'd1);
            check("hold_rdata", bus.resp_rdata, held_rdata);
            check("hold_err", 64'(bus.resp_err), 64'(held_err));
            check("hold_req_ready", 64'(bus.req_ready), 64'd0);
        end
        bus.resp_ready = 1'b1;
        step();
        bus.resp_ready = 1'b0;
        check("retire_valid", 64'(bus.resp_valid), 64'd0);
        check("men_cycles", 64'(men_cnt), ex.err ? 64'd0 : 64'd1);
        if (!ex.err && men_cnt == 1) begin
            check("raddr", cap_raddr, line_a);
            check("waddr", cap_waddr, line_a);
            check("mwen", 64'(cap_mwen), 64'(rq.wen));
            if (rq.wen) begin
                check("wmask", 64'(cap_wmask), 64'(ex.wmask));
                check("wdata", cap_wdata, ex.wdata);
            end
        end
        in_txn = 1'b0;
    endtask

    function automatic vec_t mk(input logic wen, input logic [1:0] size, input logic uns,
                                input logic [63:0] addr, input logic [63:0] wdata,
                                input logic pre, input logic [63:0] line,
                                input logic err, input logic [63:0] rdata,
                                input logic [7:0] wmask, input logic [63:0] ewdata,
                                input int hold);
        vec_t v;
        v.rq.wen   = wen;   v.rq.size  = size;  v.rq.uns = uns;
        v.rq.addr  = addr;  v.rq.wdata = wdata;
        v.preload  = pre;   v.line     = line;
        v.ex.err   = err;   v.ex.rdata = rdata;
        v.ex.wmask = wmask; v.ex.wdata = ewdata;
        v.hold     = hold;
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t  vecs[$];
        req_t  rq;
        exp_t  ex;
        exp_t  dummy;

        bus.req_valid = 1'b0; bus.req_wen = 1'b0; bus.req_size = 2'd0; bus.req_unsigned = 1'b0;
        bus.req_addr  = '0;   bus.req_wdata = '0; bus.resp_ready = 1'b0; bus.rdata = '0;
        rst = 1'b0;
        #2 rst = 1'b1;

        // Reset state.
        cur_tag = "reset";
        repeat (3) @(negedge clk);
        check("req_ready", 64'(bus.req_ready), 64'd1);
        check("resp_valid", 64'(bus.resp_valid), 64'd0);
        check("resp_err", 64'(bus.resp_err), 64'd0);
        check("resp_rdata", bus.resp_rdata, 64'd0);
        check("men", 64'(bus.men), 64'd0);
        check("mwen", 64'(bus.mwen), 64'd0);
        check("raddr", bus.raddr, 64'd0);
        check("waddr", bus.waddr, 64'd0);
        check("wdata", bus.wdata, 64'd0);
        check("wmask", 64'(bus.wmask), 64'd0);
        rst = 1'b0;
        step();

        // Byte 5 of 0x00AA_8000_0000_0000 is 0x80; the second line puts 0xAA there.
        vecs.push_back(mk(0, 2'd0, 0, 64'h8000_0005, 64'h0, 1, 64'h00AA_8000_0000_0000, 0, 64'hFFFF_FFFF_FFFF_FF80, 8'h00, 64'h0, 0));
        vecs.push_back(mk(0, 2'd0, 0, 64'h8000_0005, 64'h0, 1, 64'h0000_AA00_0000_0000, 0, 64'hFFFF_FFFF_FFFF_FFAA, 8'h00, 64'h0, 1));
        vecs.push_back(mk(0, 2'd0, 1, 64'h8000_0005, 64'h0, 0, 64'h0, 0, 64'h0000_0000_0000_00AA, 8'h00, 64'h0, 0));
        vecs.push_back(mk(1, 2'd1, 0, 64'h8000_0006, 64'h1234, 0, 64'h0, 0, 64'h0, 8'hC0, 64'h1234_0000_0000_0000, 5));
        vecs.push_back(mk(0, 2'd1, 0, 64'h8000_0006, 64'h0, 0, 64'h0, 0, 64'h0000_0000_0000_1234, 8'h00, 64'h0, 0));
        vecs.push_back(mk(0, 2'd2, 1, 64'h8000_0004, 64'h0, 1, 64'h8765_4321_0000_0000, 0, 64'h0000_0000_8765_4321, 8'h00, 64'h0, 2));
        vecs.push_back(mk(0, 2'd2, 0, 64'h8000_0004, 64'h0, 0, 64'h0, 0, 64'hFFFF_FFFF_8765_4321, 8'h00, 64'h0, 0));
        vecs.push_back(mk(0, 2'd2, 0, 64'h8000_0002, 64'h0, 0, 64'h0, 1, 64'h0, 8'h00, 64'h0, 5));
        vecs.push_back(mk(1, 2'd3, 0, 64'h8000_0008, 64'hDEAD_BEEF_0123_4567, 0, 64'h0, 0, 64'h0, 8'hFF, 64'hDEAD_BEEF_0123_4567, 1));
        vecs.push_back(mk(0, 2'd3, 0, 64'h8000_0008, 64'h0, 0, 64'h0, 0, 64'hDEAD_BEEF_0123_4567, 8'h00, 64'h0, 0));
        vecs.push_back(mk(1, 2'd0, 0, 64'h8000_0017, 64'hFFFF_FFFF_FFFF_FF5A, 0, 64'h0, 0, 64'h0, 8'h80, 64'h5A00_0000_0000_0000, 0));
        vecs.push_back(mk(1, 2'd1, 0, 64'h8000_0011, 64'hFFFF, 0, 64'h0, 1, 64'h0, 8'h00, 64'h0, 0));
        vecs.push_back(mk(0, 2'd0, 0, 64'h8000_0017, 64'h0, 0, 64'h0, 0, 64'h0000_0000_0000_005A, 8'h00, 64'h0, 0));
        vecs.push_back(mk(0, 2'd0, 1, 64'h8000_0000, 64'h0, 1, 64'h0000_0000_0000_80F0, 0, 64'h0000_0000_0000_00F0, 8'h00, 64'h0, 0));
        vecs.push_back(mk(0, 2'd1, 0, 64'h8000_0000, 64'h0, 0, 64'h0, 0, 64'hFFFF_FFFF_FFFF_80F0, 8'h00, 64'h0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            cur_tag = $sformatf("vec%0d", i);
            if (vecs[i].preload) preload({vecs[i].rq.addr[63:3], 3'b000}, vecs[i].line);
            model(vecs[i].rq, dummy);
            run_txn(vecs[i].rq, vecs[i].ex, vecs[i].hold);
        end

        // Reset asserted in the middle of a store ACCESS: port drops at once, no write lands.
        cur_tag = "reset_mid_access";
        bus.req_valid = 1'b1; bus.req_wen = 1'b1; bus.req_size = 2'd3; bus.req_unsigned = 1'b0;
        bus.req_addr  = 64'h8000_0020; bus.req_wdata = 64'hA5A5_A5A5_A5A5_A5A5;
        in_txn  = 1'b1;
        men_cnt = 0;
        step();
        bus.req_valid = 1'b0;
        check("men_in_access", 64'(bus.men), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("men_after_rst", 64'(bus.men), 64'd0);
        check("mwen_after_rst", 64'(bus.mwen), 64'd0);
        check("wmask_after_rst", 64'(bus.wmask), 64'd0);
        step();
        rst = 1'b0;
        in_txn = 1'b0;
        step();
        check("req_ready_after", 64'(bus.req_ready), 64'd1);
        check("resp_valid_after", 64'(bus.resp_valid), 64'd0);
        check("resp_rdata_after", bus.resp_rdata, 64'd0);
        for (int j = 0; j < 8; j++)
            check($sformatf("no_write_b%0d", j), 64'(dut_rd(64'h8000_0020 + 64'(j))),
                  64'(ref_rd(64'h8000_0020 + 64'(j))));
        rq.wen = 1'b0; rq.size = 2'd3; rq.uns = 1'b0; rq.addr = 64'h8000_0020; rq.wdata = '0;
        model(rq, ex);
        run_txn(rq, ex, 0);

        // Random traffic in a small window so loads revisit earlier stores.
        for (int i = 0; i < 300; i++) begin
            cur_tag  = $sformatf("rnd%0d", i);
            rq.wen   = 1'($urandom_range(0, 1));
            rq.size  = 2'($urandom_range(0, 3));
            rq.uns   = 1'($urandom_range(0, 1));
            rq.addr  = 64'h8000_0000 + 64'($urandom_range(0, 63));
            rq.wdata = {$urandom, $urandom};
            model(rq, ex);
            run_txn(rq, ex, int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
